// File: rtl/vblank_update_scheduler.sv
// vblank_update_scheduler: per-frame round-robin owner of the shared game-state commit port.
// Each requester gets at most one bounded grant per frame, and the starting slot rotates every frame.
module vblank_update_scheduler #(
  parameter int N_REQ  = 4,
  parameter int BUDGET = 1024,
  parameter int PTR_W  = 2,
  parameter int TMR_W  = 11
) (
  input  logic             pixel_clk,
  input  logic             reset,
  input  logic             frame_tick,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] done,
  input  logic             clr_status,
  output logic [N_REQ-1:0] grant,
  output logic [PTR_W-1:0] active_slot,
  output logic             busy,
  output logic             round_done,
  output logic [N_REQ-1:0] timeout_flags,
  output logic             frame_overrun
);

  typedef enum logic [1:0] {IDLE, SCAN, GRANT, FINISH} state_t;

  localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(N_REQ - 1);
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(BUDGET - 1);

  state_t           state_reg, state_next;
  logic [PTR_W-1:0] slot_reg, slot_next;
  logic [PTR_W-1:0] start_reg, start_next;
  logic [PTR_W-1:0] visited_reg, visited_next;
  logic [TMR_W-1:0] timer_reg, timer_next;
  logic [N_REQ-1:0] grant_reg, grant_next;
  logic [N_REQ-1:0] tflags_reg, tflags_next, tflag_set;
  logic             busy_reg, busy_next;
  logic             round_done_reg, round_done_next;
  logic             overrun_reg, overrun_next, overrun_set;
  logic             advance;

  logic [N_REQ-1:0] slot_onehot;
  logic             slot_req, slot_done;
  logic [PTR_W-1:0] slot_inc, start_inc;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slot_decode
      assign slot_onehot[gi] = (slot_reg == PTR_W'(gi));
    end
  endgenerate

  // Selecting through the one-hot keeps non-power-of-two N_REQ free of out-of-range indexing
  assign slot_req  = |(req & slot_onehot);
  assign slot_done = |(done & slot_onehot);
  assign slot_inc  = (slot_reg == LAST_SLOT) ? '0 : slot_reg + PTR_W'(1);
  assign start_inc = (start_reg == LAST_SLOT) ? '0 : start_reg + PTR_W'(1);

  always_comb begin
    state_next   = state_reg;
    slot_next    = slot_reg;
    start_next   = start_reg;
    visited_next = visited_reg;
    timer_next   = timer_reg;
    grant_next   = grant_reg;
    tflag_set    = '0;
    overrun_set  = 1'b0;
    advance      = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (frame_tick) begin
          state_next   = SCAN;
          slot_next    = start_reg;
          visited_next = '0;
        end
      end
      SCAN, GRANT: begin
        if (frame_tick) begin
          // Overrun wins over any done/timeout in the same cycle
          grant_next   = '0;
          overrun_set  = 1'b1;
          start_next   = start_inc;
          slot_next    = start_inc;
          visited_next = '0;
          state_next   = SCAN;
        end else if (state_reg == SCAN) begin
          if (slot_req) begin
            state_next = GRANT;
            grant_next = slot_onehot;
            timer_next = '0;
          end else begin
            advance = 1'b1;
          end
        end else begin
          timer_next = timer_reg + TMR_W'(1);
          if (slot_done) begin
            grant_next = '0;
            advance    = 1'b1;
          end else if (timer_reg == TMR_LAST) begin
            grant_next = '0;
            tflag_set  = slot_onehot;
            advance    = 1'b1;
          end
        end
      end
      FINISH: begin
        start_next = start_inc;
        if (frame_tick) begin
          state_next   = SCAN;
          slot_next    = start_inc;
          visited_next = '0;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    if (advance) begin
      if (visited_reg == LAST_SLOT) begin
        state_next = FINISH;
      end else begin
        slot_next    = slot_inc;
        visited_next = visited_reg + PTR_W'(1);
        state_next   = SCAN;
      end
    end

    busy_next       = (state_next != IDLE);
    round_done_next = (state_next == FINISH);
    // A flag being set in the same cycle as clr_status survives the clear
    tflags_next     = (tflags_reg & ~{N_REQ{clr_status}}) | tflag_set;
    overrun_next    = (overrun_reg & ~clr_status) | overrun_set;
  end

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      slot_reg       <= '0;
      start_reg      <= '0;
      visited_reg    <= '0;
      timer_reg      <= '0;
      grant_reg      <= '0;
      tflags_reg     <= '0;
      busy_reg       <= 1'b0;
      round_done_reg <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      slot_reg       <= slot_next;
      start_reg      <= start_next;
      visited_reg    <= visited_next;
      timer_reg      <= timer_next;
      grant_reg      <= grant_next;
      tflags_reg     <= tflags_next;
      busy_reg       <= busy_next;
      round_done_reg <= round_done_next;
      overrun_reg    <= overrun_next;
    end
  end

  assign grant         = grant_reg;
  assign active_slot   = slot_reg;
  assign busy          = busy_reg;
  assign round_done    = round_done_reg;
  assign timeout_flags = tflags_reg;
  assign frame_overrun = overrun_reg;

endmodule
